// File: rtl/tsp_display_ctrl.sv
// Seven-segment style display controller for a TSP solver: shows perf, a scrolling
// or stepped tour path, or a blank pattern. Optional leading-zero blanking: TSP_DISP_ZERO_BLANK_EN.
module tsp_display_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int PERF_W       = 24,
    parameter int N_CITIES     = 64,
    parameter int IDX_W        = 6,
    parameter int REFRESH_LOG2 = 17,
    parameter int SCROLL_LOG2  = 23
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         step,
    input  logic [PERF_W-1:0]            perf,
    input  logic [N_CITIES*IDX_W-1:0]    path,
    output logic [NUM_DIGITS*4-1:0]      digits,
    output logic [NUM_DIGITS-1:0]        blank,
    output logic [IDX_W-1:0]             led_idx
);

    localparam int DW = NUM_DIGITS * 4;
    localparam int HW = DW / 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CITIES - 1);

    typedef enum logic [1:0] {
        MODE_PERF   = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    mode_e                   r_mode_q;
    logic [SCROLL_LOG2-1:0]  r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_idx_chg;
    logic [DW-1:0]           r_digits;
    logic [NUM_DIGITS-1:0]   r_blank;

    logic                    w_rtick;
    logic                    w_stick;
    logic                    w_mode_chg;
    logic                    w_adv;
    logic                    w_load;
    mode_e                   w_load_mode;
    logic [IDX_W-1:0]        w_sel_idx;
    logic [IDX_W-1:0]        w_sel_nxt;
    logic [DW-1:0]           w_perf_nib;
    logic [DW-1:0]           w_path_nib;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [DW-1:0]           w_new_digits;
    logic [NUM_DIGITS-1:0]   w_new_blank;

    assign w_rtick    = (r_cnt[REFRESH_LOG2-1:0] == '0);
    assign w_stick    = (r_cnt == '0);
    assign w_mode_chg = (mode != r_mode_q);

    generate
        if (PERF_W >= DW) begin : g_perf_trunc
            assign w_perf_nib = perf[DW-1:0];
        end else begin : g_perf_ext
            assign w_perf_nib = {{(DW-PERF_W){1'b0}}, perf};
        end
    endgenerate

`ifdef TSP_DISP_ZERO_BLANK_EN
    logic w_seen;
    // Digit 0 is never dark, so a zero value still shows one "0".
    always_comb begin
        w_lz_blank = '0;
        w_seen     = 1'b0;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            w_seen        = w_seen | (|w_perf_nib[4*d +: 4]);
            w_lz_blank[d] = ~w_seen;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    // A mode change reloads from entry 0 on the same edge that clears idx.
    always_comb begin
        w_sel_idx  = w_mode_chg ? '0 : r_idx;
        w_sel_nxt  = (w_sel_idx == LAST_IDX) ? '0 : w_sel_idx + 1'b1;
        w_path_nib = '0;
        w_path_nib[IDX_W-1:0]   = path[w_sel_idx*IDX_W +: IDX_W];
        w_path_nib[HW +: IDX_W] = path[w_sel_nxt*IDX_W +: IDX_W];
    end

    always_comb begin
        w_load_mode  = w_mode_chg ? mode_e'(mode) : r_mode_q;
        w_new_digits = '1;
        w_new_blank  = '0;
        w_adv        = 1'b0;
        w_load       = w_mode_chg;
        case (w_load_mode)
            MODE_PERF: begin
                w_new_digits = w_perf_nib;
                w_new_blank  = w_lz_blank;
            end
            MODE_AUTO, MODE_MANUAL: begin
                w_new_digits = w_path_nib;
            end
            default: begin
                w_new_blank = '1;
            end
        endcase
        if (!w_mode_chg) begin
            case (r_mode_q)
                MODE_PERF:   w_load = w_rtick;
                MODE_AUTO: begin
                    w_load = w_rtick | r_idx_chg;
                    w_adv  = w_stick;
                end
                MODE_MANUAL: begin
                    w_load = w_rtick | r_idx_chg;
                    w_adv  = step;
                end
                default:     w_load = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q  <= MODE_PERF;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_idx_chg <= 1'b0;
            r_digits  <= '1;
            r_blank   <= '0;
        end else begin
            r_mode_q  <= mode_e'(mode);
            r_cnt     <= w_mode_chg ? '0 : r_cnt + 1'b1;
            r_idx_chg <= w_adv;
            if (w_mode_chg) begin
                r_idx <= '0;
            end else if (w_adv) begin
                r_idx <= w_sel_nxt;
            end
            if (w_load) begin
                r_digits <= w_new_digits;
                r_blank  <= w_new_blank;
            end
        end
    end

    assign digits  = r_digits;
    assign blank   = r_blank;
    assign led_idx = r_idx;

endmodule

// File: tb/tb_tsp_display_ctrl.sv
// Directed self-checking bench for tsp_display_ctrl with small refresh/scroll periods.
module tb_tsp_display_ctrl;

    localparam int NUM_DIGITS   = 6;
    localparam int PERF_W       = 24;
    localparam int N_CITIES     = 4;
    localparam int IDX_W        = 6;
    localparam int REFRESH_LOG2 = 2;
    localparam int SCROLL_LOG2  = 4;

`ifdef TSP_DISP_ZERO_BLANK_EN
    localparam logic [5:0] EXP_BL_3A = 6'b111100;
    localparam logic [5:0] EXP_BL_0  = 6'b111110;
`else
    localparam logic [5:0] EXP_BL_3A = 6'b000000;
    localparam logic [5:0] EXP_BL_0  = 6'b000000;
`endif

    logic                         clk = 1'b0;
    logic                         rst;
    logic [1:0]                   mode;
    logic                         step;
    logic [PERF_W-1:0]            perf;
    logic [N_CITIES*IDX_W-1:0]    path;
    logic [NUM_DIGITS*4-1:0]      digits;
    logic [NUM_DIGITS-1:0]        blank;
    logic [IDX_W-1:0]             led_idx;

    int n_checks = 0;
    int n_errors = 0;

    tsp_display_ctrl #(
        .NUM_DIGITS  (NUM_DIGITS),
        .PERF_W      (PERF_W),
        .N_CITIES    (N_CITIES),
        .IDX_W       (IDX_W),
        .REFRESH_LOG2(REFRESH_LOG2),
        .SCROLL_LOG2 (SCROLL_LOG2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .step   (step),
        .perf   (perf),
        .path   (path),
        .digits (digits),
        .blank  (blank),
        .led_idx(led_idx)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        mode = 2'd0;
        step = 1'b0;
        perf = 24'h12AB3F;
        path = {6'd3, 6'd2, 6'd1, 6'd0};
        tick(2);
        check_val("rst_digits", 32'(digits), 32'hFFFFFF);
        check_val("rst_blank", 32'(blank), 32'h0);
        check_val("rst_idx", 32'(led_idx), 32'h0);

        // Perf display, including leading-zero cases.
        rst = 1'b0;
        tick(1);
        check_val("perf_12ab3f", 32'(digits), 32'h12AB3F);
        check_val("perf_12ab3f_blank", 32'(blank), 32'h0);
        perf = 24'h00003A;
        tick(5);
        check_val("perf_3a", 32'(digits), 32'h00003A);
        check_val("perf_3a_blank", 32'(blank), 32'(EXP_BL_3A));
        perf = 24'h000000;
        tick(5);
        check_val("perf_0", 32'(digits), 32'h000000);
        check_val("perf_0_blank", 32'(blank), 32'(EXP_BL_0));
        pulse_step();
        check_val("perf_step_ignored", 32'(led_idx), 32'h0);

        // Auto-scroll: stick fires right after entry, then every 16 cycles.
        mode = 2'd1;
        tick(1);
        check_val("auto_enter_idx", 32'(led_idx), 32'h0);
        check_val("auto_enter_digits", 32'(digits), 32'h001000);
        check_val("auto_blank", 32'(blank), 32'h0);
        tick(1);
        check_val("auto_idx1", 32'(led_idx), 32'h1);
        tick(1);
        check_val("auto_idx1_digits", 32'(digits), 32'h002001);
        tick(14);
        check_val("auto_idx1_hold", 32'(led_idx), 32'h1);
        tick(1);
        check_val("auto_idx2", 32'(led_idx), 32'h2);
        tick(16);
        check_val("auto_idx3", 32'(led_idx), 32'h3);
        tick(1);
        check_val("auto_idx3_wrap_digits", 32'(digits), 32'h000003);
        tick(15);
        check_val("auto_idx_wrap0", 32'(led_idx), 32'h0);

        // Manual stepping.
        mode = 2'd2;
        tick(1);
        check_val("man_enter_idx", 32'(led_idx), 32'h0);
        check_val("man_enter_digits", 32'(digits), 32'h001000);
        tick(4);
        check_val("man_no_stick_adv", 32'(led_idx), 32'h0);
        pulse_step();
        check_val("man_step1", 32'(led_idx), 32'h1);
        pulse_step();
        check_val("man_step2", 32'(led_idx), 32'h2);
        tick(1);
        check_val("man_step2_digits", 32'(digits), 32'h003002);
        tick(12);
        check_val("man_hold2", 32'(led_idx), 32'h2);
        pulse_step();
        check_val("man_step3", 32'(led_idx), 32'h3);
        tick(1);
        check_val("man_step3_digits", 32'(digits), 32'h000003);
        tick(64);
        check_val("man_hold3_64", 32'(led_idx), 32'h3);

        // Step coinciding with a switch to auto-scroll: mode change wins.
        mode = 2'd1;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_val("step_vs_modechg_idx", 32'(led_idx), 32'h0);
        check_val("step_vs_modechg_digits", 32'(digits), 32'h001000);

        // Blank mode.
        mode = 2'd3;
        tick(2);
        check_val("blank_digits", 32'(digits), 32'hFFFFFF);
        check_val("blank_blank", 32'(blank), 32'h3F);
        pulse_step();
        check_val("blank_step_ignored", 32'(led_idx), 32'h0);

        // Reset in the middle of an auto-scroll at idx 2.
        mode = 2'd1;
        tick(18);
        check_val("mid_idx2", 32'(led_idx), 32'h2);
        rst = 1'b1;
        tick(1);
        check_val("mid_rst_idx", 32'(led_idx), 32'h0);
        check_val("mid_rst_digits", 32'(digits), 32'hFFFFFF);
        check_val("mid_rst_blank", 32'(blank), 32'h0);
        rst  = 1'b0;
        mode = 2'd0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tsp_display_ctrl.md
TSP_DISPLAY_CTRL -- requirements
Module: tsp_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of hex digits; even, >=2.
REQ-002 SHALL have parameter PERF_W, default 24, width of perf input.
REQ-003 SHALL have parameter N_CITIES, default 64, number of path entries; >=2.
REQ-004 SHALL have parameter IDX_W, default 6, width of one path entry; IDX_W <= 2*NUM_DIGITS.
REQ-005 SHALL have parameter REFRESH_LOG2, default 17, log2 of the refresh period in cycles.
REQ-006 SHALL have parameter SCROLL_LOG2, default 23, log2 of the auto-scroll period in cycles; SCROLL_LOG2 >= REFRESH_LOG2.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port mode, input, 2, where 0 = perf, 1 = path auto-scroll, 2 = path manual, 3 = blank.
REQ-010 SHALL have port step, input, 1, single-cycle advance pulse, used in mode 2 only.
REQ-011 SHALL have port perf, input, PERF_W, performance value.
REQ-012 SHALL have port path, input, N_CITIES*IDX_W, flat path bus; entry k occupies bits [k*IDX_W +: IDX_W].
REQ-013 SHALL have port digits, output, NUM_DIGITS*4, hex nibble per digit; digit d occupies bits [4d +: 4].
REQ-014 SHALL have port blank, output, NUM_DIGITS, per-digit blank flag (1 = dark).
REQ-015 SHALL have port led_idx, output, IDX_W, current path index.

Function
REQ-016 SHALL keep a free-running counter cnt of SCROLL_LOG2 bits that wraps to 0.
- rtick = (cnt[REFRESH_LOG2-1:0] == 0).
- stick = (cnt == 0).
REQ-017 SHALL register all outputs; a load decided in cycle t is visible after edge t+1.
REQ-018 SHALL register mode into mode_q; on mode != mode_q: cnt := 0, idx := 0, and digits/blank reload on the same edge from the new mode's data.
REQ-019 In mode 0, on rtick, SHALL load digit d with perf[4d +: 4].
- perf wider than 4*NUM_DIGITS: truncated.
- perf narrower: zero-extended.
- blank = 0.
REQ-020 In modes 1 and 2, H = NUM_DIGITS/2.
- SHALL load low H digits from path[idx], zero-extended.
- SHALL load high H digits from path[(idx+1) mod N_CITIES], zero-extended.
- Load occurs on rtick and on the edge following any idx change.
REQ-021 Mode 1: on stick, idx SHALL advance; idx == N_CITIES-1 wraps to 0.
REQ-022 Mode 2: on step = 1, idx SHALL advance with the same wrap; stick is ignored.
REQ-023 step SHALL be ignored in modes 0, 1 and 3.
REQ-024 If step coincides with a mode change, the mode change SHALL win and idx := 0.
REQ-025 The second displayed entry for idx = N_CITIES-1 SHALL be path[0]; never an out-of-range index.
REQ-026 In mode 3, digits SHALL be all 4'hF and blank all ones, loaded on the edge after mode 3 is entered.
REQ-027 led_idx SHALL equal idx at all times.

Reset
REQ-028 With rst = 1 at an edge, the block SHALL set:
- cnt = 0, idx = 0, mode_q = 0;
- digits = all 4'hF, blank = 0, led_idx = 0.
REQ-029 Reset SHALL override mode, step and ticks; asserting it mid-scroll SHALL abort and return to the state in REQ-028.
REQ-030 After reset release, cnt = 0, so rtick and stick fire on the first cycle.

Configuration
REQ-031 SHALL compile leading-zero suppression only under macro TSP_DISP_ZERO_BLANK_EN.
- Defined, mode 0: every digit above the most significant nonzero nibble has blank = 1; digit 0 is never blanked; perf = 0 shows a single "0".
- Undefined: blank is 0 in modes 0-2.
- Modes 1-3 are unaffected either way.

Verification
Bench params: NUM_DIGITS=6, PERF_W=24, N_CITIES=4, IDX_W=6, REFRESH_LOG2=2, SCROLL_LOG2=4.
REQ-032 Reset, mode 0, perf = 24'h12AB3F -> digits = 24'h12AB3F within 5 cycles of release; blank = 0 (macro off) / 6'b000000 (macro on).
REQ-033 Macro on, mode 0, perf = 24'h00003A -> digits low = A, 3; blank = 6'b111100; perf = 0 -> blank = 6'b111110.
REQ-034 Mode 1, path = {6'd3, 6'd2, 6'd1, 6'd0} -> idx advances 0, 1, 2, 3, 0 every 16 cycles; at idx = 3, digits = 24'h000003 low, 24'h000000 high (path[0]).
REQ-035 Mode 2 with step pulses on cycles 5, 6 and 20 -> idx = 1, 2, 3; no advance between pulses over 64 cycles; step in the same cycle as a switch to mode 1 -> idx = 0.
REQ-036 Mode 3 -> digits = 24'hFFFFFF, blank = 6'b111111; rst asserted at idx = 2 in mode 1 -> idx = 0, digits = 24'hFFFFFF, blank = 0 on the next edge.
